// File: rtl/riscv_mc_ctrl_if.sv
// Instruction/data memory handshake between the multi-cycle controller (master)
// and the instruction/data memories (slave).
interface riscv_mc_ctrl_if;
  logic       fetch_req;
  logic       imem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_action;
  logic       read_mem;
  logic       write_mem;
  logic       dmem_ready;

  modport master (
    output fetch_req, read_mem, write_mem,
    input  imem_ready, opcode, funct3, alu_action, dmem_ready
  );

  modport slave (
    input  fetch_req, read_mem, write_mem,
    output imem_ready, opcode, funct3, alu_action, dmem_ready
  );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control unit: boot/fetch/decode/exec/mem/writeback sequencing
// with variable-latency memory handshakes, timeout and illegal-opcode traps, halt, retire count.
module riscv_mc_ctrl #(
  parameter int OPR_W       = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_mc_ctrl_if.master      mem,
  input  logic                 start,
  input  logic                 zero,
  output logic                 en_pc,
  output logic [1:0]           pc_sel,
  output logic                 alu_src,
  output logic [OPR_W-1:0]     opr,
  output logic                 enx12,
  output logic                 enx20,
  output logic                 shamt,
  output logic [1:0]           memtoreg,
  output logic                 en_w,
  output logic                 done,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic                 halt,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_BOOT   = 4'd1;
  localparam logic [3:0] S_FETCH  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_EXEC   = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB     = 4'd6;
  localparam logic [3:0] S_TRAP   = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  // Wait counter only needs to reach MEM_TIMEOUT-1; the timeout fires on that cycle.
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? OP_SUB : OP_ADD;
      3'd1:    op = OP_SLL;
      3'd2:    op = OP_SLT;
      3'd3:    op = OP_SLTU;
      3'd4:    op = OP_XOR;
      3'd5:    op = alt ? OP_SRA : OP_SRL;
      3'd6:    op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    logic t;
    case (f3)
      3'd0, 3'd5, 3'd7: t = z;
      3'd1, 3'd4, 3'd6: t = !z;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

  logic [3:0]    state, state_d;
  logic [1:0]    cause_d;
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;

  logic       d_alu_src, d_enx12, d_enx20, d_shamt;
  logic [3:0] d_opr;
  logic [1:0] d_memtoreg;
  logic       d_wb, d_mem, d_store, d_branch, d_jal, d_jalr, d_legal, d_system;

  logic       wb_q, mem_q, store_q, branch_q, jal_q, jalr_q;
  logic [2:0] f3_q;

  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == TO_LAST);

  always_comb begin
    d_alu_src  = 1'b0;
    d_opr      = OP_ADD;
    d_enx12    = 1'b0;
    d_enx20    = 1'b0;
    d_shamt    = 1'b0;
    d_memtoreg = 2'b00;
    d_wb       = 1'b0;
    d_mem      = 1'b0;
    d_store    = 1'b0;
    d_branch   = 1'b0;
    d_jal      = 1'b0;
    d_jalr     = 1'b0;
    d_legal    = 1'b1;
    d_system   = 1'b0;
    case (mem.opcode)
      OPC_R: begin
        d_opr = alu_op(mem.alu_action[2:0], mem.alu_action[3]);
        d_wb  = 1'b1;
      end
      OPC_I: begin
        d_alu_src = 1'b1;
        d_wb      = 1'b1;
        d_opr     = alu_op(mem.alu_action[2:0], (mem.funct3 == 3'd5) && mem.alu_action[3]);
        if (mem.funct3 == 3'd1 || mem.funct3 == 3'd5) d_shamt = 1'b1;
        else                                          d_enx12 = 1'b1;
      end
      OPC_LOAD: begin
        d_alu_src  = 1'b1;
        d_enx12    = 1'b1;
        d_memtoreg = 2'b01;
        d_wb       = 1'b1;
        d_mem      = 1'b1;
      end
      OPC_STORE: begin
        d_alu_src = 1'b1;
        d_enx12   = 1'b1;
        d_mem     = 1'b1;
        d_store   = 1'b1;
      end
      OPC_BRANCH: begin
        d_enx12  = 1'b1;
        d_branch = 1'b1;
        case (mem.funct3)
          3'd0, 3'd1: d_opr = OP_SUB;
          3'd4, 3'd5: d_opr = OP_SLT;
          3'd6, 3'd7: d_opr = OP_SLTU;
          default:    d_legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        d_alu_src  = 1'b1;
        d_enx20    = 1'b1;
        d_memtoreg = 2'b11;
        d_wb       = 1'b1;
        d_jal      = 1'b1;
      end
      OPC_JALR: begin
        d_alu_src  = 1'b1;
        d_enx12    = 1'b1;
        d_memtoreg = 2'b11;
        d_wb       = 1'b1;
        d_jalr     = 1'b1;
      end
      OPC_LUI: begin
        d_alu_src = 1'b1;
        d_enx20   = 1'b1;
        d_wb      = 1'b1;
      end
      OPC_AUIPC: begin
        d_alu_src  = 1'b1;
        d_enx20    = 1'b1;
        d_memtoreg = 2'b10;
        d_wb       = 1'b1;
      end
      OPC_SYSTEM: d_system = 1'b1;
      default:    d_legal  = 1'b0;
    endcase
  end

  // A ready arriving on the timeout cycle is checked first, so it wins over the trap.
  always_comb begin
    state_d = state;
    cause_d = 2'b00;
    case (state)
      S_IDLE, S_TRAP, S_HALT: if (start) state_d = S_BOOT;
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ready) state_d = S_DECODE;
        else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        if (d_system) state_d = S_HALT;
        else if (!d_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else state_d = S_EXEC;
      end
      S_EXEC: state_d = mem_q ? S_MEM : S_WB;
      S_MEM: begin
        if (mem.dmem_ready) state_d = S_WB;
        else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      mem.fetch_req <= 1'b0;
      mem.read_mem  <= 1'b0;
      mem.write_mem <= 1'b0;
      en_pc         <= 1'b0;
      pc_sel        <= 2'b00;
      alu_src       <= 1'b0;
      opr           <= '0;
      enx12         <= 1'b0;
      enx20         <= 1'b0;
      shamt         <= 1'b0;
      memtoreg      <= 2'b00;
      en_w          <= 1'b0;
      done          <= 1'b0;
      trap          <= 1'b0;
      trap_cause    <= 2'b00;
      halt          <= 1'b0;
      retired       <= '0;
      wb_q          <= 1'b0;
      mem_q         <= 1'b0;
      store_q       <= 1'b0;
      branch_q      <= 1'b0;
      jal_q         <= 1'b0;
      jalr_q        <= 1'b0;
      f3_q          <= 3'd0;
    end else begin
      state <= state_d;
      if (state_d != state)                      wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM) wait_cnt <= wait_cnt + TW'(1);

      // Moore outputs: each register reflects the state being entered.
      mem.fetch_req <= (state_d == S_FETCH);
      mem.read_mem  <= (state_d == S_MEM) && !store_q;
      mem.write_mem <= (state_d == S_MEM) && store_q;
      en_pc         <= (state_d == S_BOOT) || (state_d == S_WB);
      en_w          <= (state_d == S_WB) && wb_q;
      done          <= (state_d == S_WB);
      trap          <= (state_d == S_TRAP);
      halt          <= (state_d == S_HALT);
      trap_cause    <= (state_d != S_TRAP) ? 2'b00 :
                       (state == S_TRAP)   ? trap_cause : cause_d;

      if (state_d == S_BOOT)    pc_sel <= 2'b11;
      else if (state_d == S_WB) pc_sel <= jalr_q ? 2'b10 :
                                          (jal_q || (branch_q && branch_taken(f3_q, zero))) ? 2'b01 : 2'b00;
      else                      pc_sel <= 2'b00;

      if (state_d == S_WB) retired <= retired + CNT_W'(1);

      if (state == S_DECODE && state_d == S_EXEC) begin
        alu_src  <= d_alu_src;
        opr      <= OPR_W'(d_opr);
        enx12    <= d_enx12;
        enx20    <= d_enx20;
        shamt    <= d_shamt;
        memtoreg <= d_memtoreg;
        wb_q     <= d_wb;
        mem_q    <= d_mem;
        store_q  <= d_store;
        branch_q <= d_branch;
        jal_q    <= d_jal;
        jalr_q   <= d_jalr;
        f3_q     <= mem.funct3;
      end else if (state_d == S_TRAP || state_d == S_HALT) begin
        alu_src  <= 1'b0;
        opr      <= '0;
        enx12    <= 1'b0;
        enx20    <= 1'b0;
        shamt    <= 1'b0;
        memtoreg <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: boot, ALU stream, branches, immediates, jumps,
// load with dmem wait, traps/halt/restart and asynchronous reset mid-store.
module tb_riscv_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, zero;
  logic        en_pc, alu_src, enx12, enx20, shamt, en_w, done, trap, halt;
  logic [1:0]  pc_sel, memtoreg, trap_cause;
  logic [4:0]  opr;
  logic [31:0] retired;
  logic [22:0] outs;
  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_ret = 0;

  riscv_mc_ctrl_if bus();

  riscv_mc_ctrl #(.OPR_W(5), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem(bus), .start(start), .zero(zero),
    .en_pc(en_pc), .pc_sel(pc_sel), .alu_src(alu_src), .opr(opr),
    .enx12(enx12), .enx20(enx20), .shamt(shamt), .memtoreg(memtoreg),
    .en_w(en_w), .done(done), .trap(trap), .trap_cause(trap_cause),
    .halt(halt), .retired(retired)
  );

  always #5 clk = ~clk;

  assign outs = {bus.fetch_req, en_pc, pc_sel, alu_src, opr, enx12, enx20, shamt,
                 bus.read_mem, bus.write_mem, memtoreg, en_w, done, trap, trap_cause, halt};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total_cnt++; if (outs !== 23'd0) $display("FAIL reset_outs: got %h want 0", outs); else pass_cnt++;
    total_cnt++; if (retired !== 32'd0) $display("FAIL reset_retired: got %0d want 0", retired); else pass_cnt++;
    rst = 1'b0;
    repeat (2) tick();
    total_cnt++; if (outs !== 23'd0) $display("FAIL idle_outs: got %h want 0", outs); else pass_cnt++;
  endtask

  task automatic test_boot();
    start = 1'b1;
    tick();
    total_cnt++; if (en_pc !== 1'b1) $display("FAIL boot_en_pc: got %0d want 1", en_pc); else pass_cnt++;
    total_cnt++; if (pc_sel !== 2'b11) $display("FAIL boot_pc_sel: got %0d want 3", pc_sel); else pass_cnt++;
    total_cnt++; if (bus.fetch_req !== 1'b0) $display("FAIL boot_fetch_req: got %0d want 0", bus.fetch_req); else pass_cnt++;
    start = 1'b0;
    tick();
    total_cnt++; if (bus.fetch_req !== 1'b1) $display("FAIL boot_fetch: got %0d want 1", bus.fetch_req); else pass_cnt++;
    total_cnt++; if (en_pc !== 1'b0) $display("FAIL boot_en_pc_drop: got %0d want 0", en_pc); else pass_cnt++;
  endtask

  task automatic test_add_stream();
    bus.opcode = 7'b0110011; bus.funct3 = 3'd0; bus.alu_action = 4'd0; bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (done !== 1'b0 || bus.fetch_req !== 1'b0) $display("FAIL add_decode: done %0d fetch %0d want 0 0", done, bus.fetch_req); else pass_cnt++;
      tick();
      total_cnt++; if (opr !== 5'd0 || alu_src !== 1'b0 || en_w !== 1'b0) $display("FAIL add_exec: opr %0d src %0d en_w %0d want 0 0 0", opr, alu_src, en_w); else pass_cnt++;
      tick();
      exp_ret++;
      total_cnt++; if (done !== 1'b1 || en_w !== 1'b1 || en_pc !== 1'b1) $display("FAIL add_wb: done %0d en_w %0d en_pc %0d want 1 1 1", done, en_w, en_pc); else pass_cnt++;
      total_cnt++; if (pc_sel !== 2'b00 || memtoreg !== 2'b00) $display("FAIL add_wb_sel: pc_sel %0d memtoreg %0d want 0 0", pc_sel, memtoreg); else pass_cnt++;
      total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL add_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
      tick();
      total_cnt++; if (done !== 1'b0 || en_w !== 1'b0 || bus.fetch_req !== 1'b1) $display("FAIL add_next_fetch: done %0d en_w %0d fetch %0d want 0 0 1", done, en_w, bus.fetch_req); else pass_cnt++;
    end
  endtask

  task automatic test_branches();
    logic [2:0] bf3 [3] = '{3'd0, 3'd4, 3'd7};
    logic [4:0] bop [3] = '{5'd1, 5'd11, 5'd5};
    logic [1:0] bsel [3] = '{2'b01, 2'b00, 2'b01};
    zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 7'b1100011; bus.funct3 = bf3[i]; bus.alu_action = {1'b0, bf3[i]};
      tick();
      tick();
      total_cnt++; if (opr !== bop[i] || enx12 !== 1'b1 || alu_src !== 1'b0) $display("FAIL br%0d_exec: opr %0d enx12 %0d src %0d want %0d 1 0", i, opr, enx12, alu_src, bop[i]); else pass_cnt++;
      tick();
      exp_ret++;
      total_cnt++; if (pc_sel !== bsel[i]) $display("FAIL br%0d_pc_sel: got %0d want %0d", i, pc_sel, bsel[i]); else pass_cnt++;
      total_cnt++; if (en_w !== 1'b0 || done !== 1'b1 || en_pc !== 1'b1) $display("FAIL br%0d_wb: en_w %0d done %0d en_pc %0d want 0 1 1", i, en_w, done, en_pc); else pass_cnt++;
      tick();
    end
    total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL br_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
  endtask

  task automatic test_imm();
    bus.opcode = 7'b0010011; bus.funct3 = 3'd5; bus.alu_action = 4'b1101;
    tick(); tick();
    total_cnt++; if (opr !== 5'd10 || shamt !== 1'b1 || enx12 !== 1'b0 || alu_src !== 1'b1) $display("FAIL srai_exec: opr %0d shamt %0d enx12 %0d src %0d want 10 1 0 1", opr, shamt, enx12, alu_src); else pass_cnt++;
    tick(); exp_ret++;
    total_cnt++; if (en_w !== 1'b1 || memtoreg !== 2'b00) $display("FAIL srai_wb: en_w %0d memtoreg %0d want 1 0", en_w, memtoreg); else pass_cnt++;
    tick();
    bus.funct3 = 3'd0; bus.alu_action = 4'b1000;
    tick(); tick();
    total_cnt++; if (opr !== 5'd0 || shamt !== 1'b0 || enx12 !== 1'b1) $display("FAIL addi_exec: opr %0d shamt %0d enx12 %0d want 0 0 1", opr, shamt, enx12); else pass_cnt++;
    tick(); exp_ret++;
    tick();
  endtask

  task automatic test_jumps();
    bus.opcode = 7'b1101111; bus.funct3 = 3'd0; bus.alu_action = 4'd0;
    tick(); tick();
    total_cnt++; if (enx20 !== 1'b1 || memtoreg !== 2'b11) $display("FAIL jal_exec: enx20 %0d memtoreg %0d want 1 3", enx20, memtoreg); else pass_cnt++;
    tick(); exp_ret++;
    total_cnt++; if (pc_sel !== 2'b01 || en_w !== 1'b1) $display("FAIL jal_wb: pc_sel %0d en_w %0d want 1 1", pc_sel, en_w); else pass_cnt++;
    tick();
    bus.opcode = 7'b1100111;
    tick(); tick();
    total_cnt++; if (enx12 !== 1'b1 || opr !== 5'd0 || memtoreg !== 2'b11) $display("FAIL jalr_exec: enx12 %0d opr %0d memtoreg %0d want 1 0 3", enx12, opr, memtoreg); else pass_cnt++;
    tick(); exp_ret++;
    total_cnt++; if (pc_sel !== 2'b10 || en_w !== 1'b1) $display("FAIL jalr_wb: pc_sel %0d en_w %0d want 2 1", pc_sel, en_w); else pass_cnt++;
    tick();
  endtask

  task automatic test_load_wait();
    int rd_cycles = 0;
    int early_done = 0;
    bus.opcode = 7'b0000011; bus.funct3 = 3'd2; bus.alu_action = 4'd2; bus.dmem_ready = 1'b0;
    tick(); tick();
    total_cnt++; if (memtoreg !== 2'b01 || opr !== 5'd0 || enx12 !== 1'b1 || bus.read_mem !== 1'b0) $display("FAIL load_exec: memtoreg %0d opr %0d enx12 %0d rd %0d want 1 0 1 0", memtoreg, opr, enx12, bus.read_mem); else pass_cnt++;
    for (int cyc = 4; cyc <= 7; cyc++) begin
      tick();
      if (bus.read_mem === 1'b1) rd_cycles++;
      if (done === 1'b1) early_done++;
      if (cyc == 7) bus.dmem_ready = 1'b1;
    end
    total_cnt++; if (rd_cycles != 4) $display("FAIL load_read_cycles: got %0d want 4", rd_cycles); else pass_cnt++;
    total_cnt++; if (early_done != 0) $display("FAIL load_early_done: got %0d want 0", early_done); else pass_cnt++;
    tick(); exp_ret++;
    total_cnt++; if (done !== 1'b1 || en_w !== 1'b1 || bus.read_mem !== 1'b0 || trap !== 1'b0) $display("FAIL load_wb: done %0d en_w %0d rd %0d trap %0d want 1 1 0 0", done, en_w, bus.read_mem, trap); else pass_cnt++;
    total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL load_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
    bus.dmem_ready = 1'b0;
    tick();
  endtask

  task automatic test_faults();
    bus.opcode = 7'b1111111;
    tick(); tick();
    total_cnt++; if (trap !== 1'b1 || trap_cause !== 2'b01) $display("FAIL illegal_trap: trap %0d cause %0d want 1 1", trap, trap_cause); else pass_cnt++;
    total_cnt++; if (bus.fetch_req !== 1'b0 || en_w !== 1'b0 || en_pc !== 1'b0) $display("FAIL illegal_strobes: fetch %0d en_w %0d en_pc %0d want 0 0 0", bus.fetch_req, en_w, en_pc); else pass_cnt++;
    tick();
    total_cnt++; if (trap !== 1'b1 || trap_cause !== 2'b01) $display("FAIL illegal_hold: trap %0d cause %0d want 1 1", trap, trap_cause); else pass_cnt++;
    start = 1'b1;
    tick();
    total_cnt++; if (trap !== 1'b0 || trap_cause !== 2'b00 || en_pc !== 1'b1 || pc_sel !== 2'b11) $display("FAIL restart_boot: trap %0d cause %0d en_pc %0d pc_sel %0d want 0 0 1 3", trap, trap_cause, en_pc, pc_sel); else pass_cnt++;
    start = 1'b0; bus.imem_ready = 1'b0;
    tick();
    repeat (3) tick();
    total_cnt++; if (trap !== 1'b0 || bus.fetch_req !== 1'b1) $display("FAIL imem_wait: trap %0d fetch %0d want 0 1", trap, bus.fetch_req); else pass_cnt++;
    tick();
    total_cnt++; if (trap !== 1'b1 || trap_cause !== 2'b10 || bus.fetch_req !== 1'b0) $display("FAIL imem_timeout: trap %0d cause %0d fetch %0d want 1 2 0", trap, trap_cause, bus.fetch_req); else pass_cnt++;
    total_cnt++; if (retired !== 32'(exp_ret)) $display("FAIL trap_retired: got %0d want %0d", retired, exp_ret); else pass_cnt++;
    start = 1'b1; bus.imem_ready = 1'b1; bus.opcode = 7'b1110011;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (halt !== 1'b1 || trap !== 1'b0 || done !== 1'b0 || en_pc !== 1'b0) $display("FAIL halt: halt %0d trap %0d done %0d en_pc %0d want 1 0 0 0", halt, trap, done, en_pc); else pass_cnt++;
    tick();
    total_cnt++; if (halt !== 1'b1) $display("FAIL halt_hold: got %0d want 1", halt); else pass_cnt++;
    start = 1'b1; bus.opcode = 7'b0110011;
    tick();
    total_cnt++; if (halt !== 1'b0 || en_pc !== 1'b1) $display("FAIL halt_restart: halt %0d en_pc %0d want 0 1", halt, en_pc); else pass_cnt++;
    start = 1'b0;
    tick();
    bus.opcode = 7'b0100011; bus.funct3 = 3'd2; bus.alu_action = 4'd2; bus.dmem_ready = 1'b0;
    tick(); tick(); tick();
    repeat (3) tick();
    total_cnt++; if (bus.write_mem !== 1'b1 || trap !== 1'b0) $display("FAIL dmem_wait: wr %0d trap %0d want 1 0", bus.write_mem, trap); else pass_cnt++;
    tick();
    total_cnt++; if (trap !== 1'b1 || trap_cause !== 2'b11 || bus.write_mem !== 1'b0 || en_w !== 1'b0 || en_pc !== 1'b0) $display("FAIL dmem_timeout: trap %0d cause %0d wr %0d en_w %0d en_pc %0d want 1 3 0 0 0", trap, trap_cause, bus.write_mem, en_w, en_pc); else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_during_mem();
    bus.opcode = 7'b0100011; bus.funct3 = 3'd2; bus.alu_action = 4'd2; bus.dmem_ready = 1'b0;
    tick(); tick(); tick();
    total_cnt++; if (bus.write_mem !== 1'b1 || en_w !== 1'b0) $display("FAIL store_mem: wr %0d en_w %0d want 1 0", bus.write_mem, en_w); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (outs !== 23'd0) $display("FAIL async_reset_outs: got %h want 0", outs); else pass_cnt++;
    total_cnt++; if (retired !== 32'd0) $display("FAIL async_reset_retired: got %0d want 0", retired); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();
    total_cnt++; if (outs !== 23'd0) $display("FAIL post_reset_idle: got %h want 0", outs); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; zero = 1'b0;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.alu_action = 4'd0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    test_reset();
    test_boot();
    test_add_stream();
    test_branches();
    test_imm();
    test_jumps();
    test_load_wait();
    test_faults();
    test_reset_during_mem();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Parameterised multi-cycle control unit for the RV32I single-issue datapath; successor to the fixed-timing instruction controller. It sequences fetch/decode/execute/memory/writeback per instruction and decodes opcode/funct fields into ALU, immediate, register-file, memory and PC-select controls. New capabilities:
- variable-latency instruction and data memory via ready handshakes, with timeout;
- illegal-opcode trap and a SYSTEM-opcode halt;
- a retired-instruction counter.

## Interface
- OPR_W, 5: ALU operation code width (≥4).
- CNT_W, 32: retired-instruction counter width.
- MEM_TIMEOUT, 16: max wait cycles for imem_ready/dmem_ready; 0 disables timeout.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution (sampled in IDLE, TRAP, HALT).
- opcode  in  7  instruction[6:0]; valid while imem_ready=1 in FETCH and stable thereafter until next FETCH.
- funct3  in  3  instruction[14:12].
- alu_action  in  4  {instruction[30], funct3}.
- zero  in  1  ALU result==0 flag.
- imem_ready  in  1  instruction-memory response valid.
- dmem_ready  in  1  data-memory access complete.
- fetch_req  out  1  instruction fetch request.
- en_pc  out  1  PC register write enable.
- pc_sel  out  2  00 pc+4, 01 pc+imm, 10 ALU result, 11 reset vector.
- alu_src  out  1  0 rs2, 1 immediate.
- opr  out  OPR_W  ADD0 SUB1 AND2 OR3 XOR4 SLTU5 SLL8 SRL9 SRA10 SLT11.
- enx12 / enx20 / shamt  out  1 each  immediate-format select (12-bit, 20-bit, shift amount).
- read_mem / write_mem  out  1 each  data-memory strobes.
- memtoreg  out  2  00 ALU, 01 memory, 10 pc+imm, 11 pc+4.
- en_w  out  1  register-file write enable.
- done  out  1  one-cycle pulse per retired instruction.
- trap  out  1  trap state indicator.
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- halt  out  1  halted by SYSTEM opcode (1110011).
- retired  out  CNT_W  retired-instruction count.

## Operation
- All outputs are registered (Moore). On reset, every output is 0, the state is IDLE, and the timeout counter is cleared.
- **IDLE:** start=1 -> BOOT.
- **BOOT (1 cycle):** en_pc=1, pc_sel=11 -> FETCH.
- **FETCH:** fetch_req=1 held until imem_ready.
  - imem_ready=1 -> DECODE.
  - Otherwise the wait counter increments. Reaching MEM_TIMEOUT (when nonzero) -> TRAP, cause 10.
- **DECODE:** latch control fields from opcode/funct3/alu_action.
  - SYSTEM opcode -> HALT.
  - Opcode not in {R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC}, or branch funct3 ∈ {2,3} -> TRAP, cause 01.
- **R:** alu_src=0, opr from alu_action; en_w pending, memtoreg=00.
- **I:** alu_src=1, enx12=1.
  - Shifts (funct3 1/5) instead use shamt=1, enx12=0; SRA when alu_action[3]=1.
  - alu_action[3] is ignored for other funct3 values.
- **LOAD:** ADD, enx12, memtoreg=01.
- **STORE:** ADD, enx12, no en_w.
- **BRANCH:** alu_src=0, enx12.
  - funct3 0/1: SUB.
  - funct3 4/5: SLT.
  - funct3 6/7: SLTU.
- **JAL:** enx20, memtoreg=11.
- **JALR:** ADD, enx12, memtoreg=11.
- **LUI:** ADD, enx20, memtoreg=00.
- **AUIPC:** enx20, memtoreg=10.
- **EXEC (1 cycle):** ALU evaluates. LOAD/STORE -> MEM; all other opcodes -> WB.
- **MEM:** read_mem or write_mem held until dmem_ready=1 -> WB. Timeout -> TRAP, cause 11 (no en_w, no en_pc).
- **WB (1 cycle):**
  - en_w=1 for all opcodes except STORE/BRANCH.
  - en_pc=1 with pc_sel:
    - branch taken -> 01. Taken is zero for funct3 0/5/7, and !zero for funct3 1/4/6; not taken -> 00.
    - JAL -> 01.
    - JALR -> 10.
    - all others -> 00.
  - done=1; retired increments, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- **TRAP / HALT:** all strobes 0; trap or halt held at 1. start=1 -> BOOT, which clears trap, trap_cause and halt. retired is not cleared.

## Timing
- Per-instruction cycle count with zero-wait memory:
  - ALU/branch/jump: FETCH, DECODE, EXEC, WB = 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- A timeout fires on the cycle the counter reaches MEM_TIMEOUT with ready still 0. A ready arriving on that same cycle wins: no trap.
- The wait counter resets on entry to FETCH and to MEM.
- Done-to-next-done spacing is ≥4 cycles.
- start outside IDLE, TRAP and HALT is ignored.
- rst asserted mid-instruction: outputs drop to 0 asynchronously. No partial en_w or write_mem may survive.
- en_w, en_pc and done assert only in WB (en_pc also in BOOT), each for exactly one cycle.

## Test plan
- **Boot:** rst, then start=1 -> BOOT pulse en_pc=1, pc_sel=11; fetch_req=1 on the next cycle.
- **ADD stream:** opcode 0110011, alu_action 0000, imem_ready=1 constantly -> done every 4 cycles, en_w=1 in WB, retired 0->1->2->3.
- **Branches:** BEQ with zero=1 -> pc_sel=01; BLT (funct3 4) with zero=1 -> pc_sel=00; BGEU with zero=1 -> pc_sel=01; en_w=0 in all cases.
- **Load with dmem wait:** LOAD with dmem_ready low for 3 cycles -> read_mem held for 4 cycles, memtoreg=01, done on cycle 8.
- **Faults:**
  - opcode 1111111 -> trap=1, cause 01.
  - MEM_TIMEOUT=4 with imem_ready stuck 0 -> trap, cause 10, 4 cycles after entering FETCH.
  - opcode 1110011 -> halt=1.
  - start -> BOOT.
- **Reset during MEM:** rst while write_mem=1 -> all outputs 0 immediately; retired=0.
